// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-controller signal bundle; master = controller, slave = pipeline
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic             exMemRead;
  logic [4:0]       exRt;
  logic             branchTaken;
  logic             memStageRead;
  logic             memStageWrite;
  logic             memReady;
  logic             memReq;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExBubble;
  logic             exMemWrite;
  logic             memWbBubble;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCount;

  modport master (
    input  idRs, idRt, exMemRead, exRt, branchTaken,
           memStageRead, memStageWrite, memReady,
    output memReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble,
           exMemWrite, memWbBubble, memTimeout, stallCount
  );

  modport slave (
    output idRs, idRt, exMemRead, exRt, branchTaken,
           memStageRead, memStageWrite, memReady,
    input  memReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble,
           exMemWrite, memWbBubble, memTimeout, stallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with memory timeout
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  pipeline_hazard_ctrl_if.master hz
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_op, load_use, mem_stall;
  logic mem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble;

  // Hazard detection terms; a load into r0 never creates a dependency
  always_comb begin
    mem_op    = hz.memStageRead | hz.memStageWrite;
    load_use  = hz.exMemRead && (hz.exRt != 5'd0) &&
                ((hz.exRt == hz.idRs) || (hz.exRt == hz.idRt));
    mem_stall = mem_op & ~hz.memReady;
  end

  // Control outputs: memory stall beats branch flush beats load-use bubble
  always_comb begin
    mem_req       = mem_op;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (state_q == HALT) begin
      mem_req       = 1'b0;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; ID/EX simply holds its contents
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (hz.branchTaken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Next state, wait counter, sticky timeout and saturating stall counter
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q == TIMEOUT_LIM) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // Access completed or the request was withdrawn
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      end
      default: state_d = HALT;
    endcase
    if (!pc_write && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.memReq      = mem_req;
  assign hz.pcWrite     = pc_write;
  assign hz.ifIdWrite   = if_id_write;
  assign hz.ifIdFlush   = if_id_flush;
  assign hz.idExBubble  = id_ex_bubble;
  assign hz.exMemWrite  = ex_mem_write;
  assign hz.memWbBubble = mem_wb_bubble;
  assign hz.memTimeout  = timeout_q;
  assign hz.stallCount  = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clock;
  logic resetN;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) pif ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  pif_s ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clock (clock),
    .resetN(resetN),
    .hz    (pif)
  );

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(255), .CNT_W(4)) dut_s (
    .clock (clock),
    .resetN(resetN),
    .hz    (pif_s)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ld;
    logic [4:0] ex_rt;
    logic       br;
    logic       mrd;
    logic       mwr;
    logic       mrdy;
    logic [6:0] exp;
    int         exp_sc;
  } vec_t;

  vec_t vt[11];
  int   n_tests;
  int   n_fail;

  // {memReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble}
  localparam logic [6:0] O_RUN    = 7'b0110010;
  localparam logic [6:0] O_RUNREQ = 7'b1110010;
  localparam logic [6:0] O_MSTALL = 7'b1000001;
  localparam logic [6:0] O_HALT   = 7'b0000001;

  function automatic logic [6:0] outs();
    return {pif.memReq, pif.pcWrite, pif.ifIdWrite, pif.ifIdFlush,
            pif.idExBubble, pif.exMemWrite, pif.memWbBubble};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    pif.idRs          = v.rs;
    pif.idRt          = v.rt;
    pif.exMemRead     = v.ld;
    pif.exRt          = v.ex_rt;
    pif.branchTaken   = v.br;
    pif.memStageRead  = v.mrd;
    pif.memStageWrite = v.mwr;
    pif.memReady      = v.mrdy;
  endtask

  task automatic mem(input logic rd, input logic rdy, input logic br);
    pif.idRs = 5'd0; pif.idRt = 5'd0; pif.exMemRead = 1'b0; pif.exRt = 5'd0;
    pif.memStageWrite = 1'b0;
    pif.memStageRead  = rd;
    pif.memReady      = rdy;
    pif.branchTaken   = br;
  endtask

  // Moves to 1 time unit after the next falling edge
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges, released on a falling edge
  task automatic async_reset_assert();
    #2 resetN = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pif_s.idRs = 5'd0; pif_s.idRt = 5'd0; pif_s.exMemRead = 1'b0; pif_s.exRt = 5'd0;
    pif_s.branchTaken = 1'b0; pif_s.memStageRead = 1'b0; pif_s.memStageWrite = 1'b0;
    pif_s.memReady = 1'b0;
    mem(1'b0, 1'b0, 1'b0);

    vt[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,      0};
    vt[1]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110, 0};
    vt[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,      1};
    vt[3]  = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110, 1};
    vt[4]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0111110, 2};
    vt[5]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,      2};
    vt[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUNREQ,   2};
    vt[7]  = '{5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1000110, 2};
    vt[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN,      3};
    vt[9]  = '{5'd2, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,      3};
    vt[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1111110, 3};

    // Reset state: outputs take RUN values for current inputs
    resetN = 1'b0;
    #3;
    chk("rst_outs",    int'(outs()), int'(O_RUN));
    chk("rst_sc",      int'(pif.stallCount), 0);
    chk("rst_timeout", int'(pif.memTimeout), 0);
    mem(1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_memstall_outs", int'(outs()), int'(O_MSTALL));
    mem(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetN = 1'b1;

    // Single-cycle vectors from RUN
    for (int i = 0; i < 11; i++) begin
      step();
      set_in(vt[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), int'(outs()), int'(vt[i].exp));
      chk($sformatf("vec%0d_sc", i), int'(pif.stallCount), vt[i].exp_sc);
    end
    step();
    mem(1'b0, 1'b0, 1'b0);
    #1;
    chk("vec_end_sc",    int'(pif.stallCount), 3);
    chk("vec_end_state", int'(dut.state_q), 0);

    // Memory wait: 3 stall cycles (branch ignored in the middle one), then ready
    for (int i = 0; i < 3; i++) begin
      mem(1'b1, 1'b0, (i == 1));
      #1;
      chk($sformatf("mwait%0d_outs", i), int'(outs()), int'(O_MSTALL));
      chk($sformatf("mwait%0d_sc", i), int'(pif.stallCount), 3 + i);
      step();
    end
    chk("mwait_state", int'(dut.state_q), 1);
    mem(1'b1, 1'b1, 1'b0);
    #1;
    chk("mwait_done_outs", int'(outs()), int'(O_RUNREQ));
    step();
    mem(1'b0, 1'b0, 1'b0);
    #1;
    chk("mwait_after_state", int'(dut.state_q), 0);
    chk("mwait_after_sc",    int'(pif.stallCount), 6);

    // Timeout with TIMEOUT_CYCLES=4: HALT after the 5th stall cycle
    async_reset_assert();
    step();
    resetN = 1'b1;
    mem(1'b1, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to%0d_outs", i), int'(outs()), int'(O_MSTALL));
      chk($sformatf("to%0d_flag", i), int'(pif.memTimeout), 0);
      step();
    end
    chk("to_halt_outs", int'(outs()), int'(O_HALT));
    chk("to_halt_flag", int'(pif.memTimeout), 1);
    chk("to_halt_sc",   int'(pif.stallCount), 5);
    mem(1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("to_ready_outs", int'(outs()), int'(O_HALT));
    chk("to_ready_flag", int'(pif.memTimeout), 1);
    chk("to_ready_sc",   int'(pif.stallCount), 5);

    // Asynchronous reset out of HALT, no clock edge
    async_reset_assert();
    chk("rst_halt_flag",  int'(pif.memTimeout), 0);
    chk("rst_halt_sc",    int'(pif.stallCount), 0);
    chk("rst_halt_state", int'(dut.state_q), 0);
    chk("rst_halt_outs",  int'(outs()), int'(O_RUNREQ));
    @(negedge clock);
    resetN = 1'b1;
    mem(1'b0, 1'b0, 1'b0);

    // Reset asserted mid MEM_WAIT, then resume
    step();
    mem(1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("mid_pre_state", int'(dut.state_q), 1);
    chk("mid_pre_sc",    int'(pif.stallCount), 2);
    async_reset_assert();
    chk("mid_rst_state", int'(dut.state_q), 0);
    chk("mid_rst_sc",    int'(pif.stallCount), 0);
    chk("mid_rst_req",   int'(pif.memReq), 1);
    chk("mid_rst_flag",  int'(pif.memTimeout), 0);
    @(negedge clock);
    resetN = 1'b1;
    step();
    chk("mid_resume_state", int'(dut.state_q), 1);
    chk("mid_resume_sc",    int'(pif.stallCount), 1);
    mem(1'b1, 1'b1, 1'b0);
    step();
    mem(1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_resume_done", int'(dut.state_q), 0);

    // Saturation with CNT_W=4
    pif_s.memStageRead = 1'b1;
    pif_s.memReady     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 16 || i == 20)
        chk($sformatf("sat%0d_sc", i), int'(pif_s.stallCount), (i < 15) ? i : 15);
    end
    chk("sat_pc", int'(pif_s.pcWrite), 0);
    pif_s.memStageRead = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives write-enables and bubble-inserts for PC, IF/ID, ID/EX, EX/MEM and the MEM/WB register.
- Resolves three event classes with fixed priority: multi-cycle data-memory wait, taken-branch flush, load-use hazard.
- Detects data-memory timeouts and halts the pipeline.
- Counts stall cycles for performance analysis.

Parameters:
- TIMEOUT_CYCLES, 255: MEM_WAIT cycles before a timeout is declared; legal range 1..255.
- CNT_W, 16: width of stallCount.

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- exMemRead  in  1  instruction in EX is a load.
- exRt  in  5  destination rt of the instruction in EX.
- branchTaken  in  1  branch resolved taken in EX this cycle.
- memStageRead  in  1  instruction in MEM is a load.
- memStageWrite  in  1  instruction in MEM is a store.
- memReady  in  1  data memory completes the MEM-stage access this cycle.
- memReq  out  1  data-memory access request.
- pcWrite  out  1  PC update enable.
- ifIdWrite  out  1  IF/ID write enable.
- ifIdFlush  out  1  clear IF/ID to NOP.
- idExBubble  out  1  load zero control into ID/EX.
- exMemWrite  out  1  EX/MEM write enable.
- memWbBubble  out  1  force wbControlInput to 2'b00 into MEM/WB; data fields still captured.
- memTimeout  out  1  sticky timeout flag.
- stallCount  out  CNT_W  saturating stall-cycle counter.

Behaviour:
- State register: RUN, MEM_WAIT, HALT. Async reset (resetN=0) forces:
  - state=RUN, waitCnt=0, memTimeout=0, stallCount=0.
  - Control outputs are combinational from state and inputs, so during reset they take RUN values for the current inputs.
- Derived signals:
  - memOp = memStageRead | memStageWrite.
  - loadUse = exMemRead & exRt!=0 & (exRt==idRs | exRt==idRt).
  - memStall = memOp & ~memReady.
- memReq = memOp while state is RUN or MEM_WAIT; 0 in HALT.
- Default outputs (RUN, no event): pcWrite=1, ifIdWrite=1, exMemWrite=1; ifIdFlush=0, idExBubble=0, memWbBubble=0.
- Priority 1, memStall (RUN or MEM_WAIT):
  - pcWrite=0, ifIdWrite=0, exMemWrite=0, idExBubble=0 (ID/EX holds), memWbBubble=1.
  - branchTaken and loadUse are ignored this cycle; EX is frozen, so they re-present next cycle.
- Priority 2, branchTaken (no memStall):
  - ifIdFlush=1, idExBubble=1; pcWrite=1 (loads target), ifIdWrite=1.
  - loadUse ignored; the ID instruction is wrong-path.
- Priority 3, loadUse (no memStall, no branchTaken):
  - pcWrite=0, ifIdWrite=0, idExBubble=1.
  - Exactly one bubble, because the load then leaves EX.
- Transitions:
  - RUN -> MEM_WAIT when memStall; waitCnt<=1.
  - MEM_WAIT and memReady=1: this cycle uses normal RUN outputs (access completes, pipeline advances); next state RUN, waitCnt<=0.
  - MEM_WAIT and memStall: if waitCnt==TIMEOUT_CYCLES, next state HALT and memTimeout<=1; otherwise waitCnt<=waitCnt+1.
  - MEM_WAIT and memOp dropped (not legal): return to RUN, no timeout.
  - HALT: every write enable 0, memWbBubble=1, memReq=0. HALT is left only via resetN.
- stallCount:
  - Increments each cycle in which pcWrite=0 and state!=HALT.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Branch flush cycles do not count.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared; memReq then follows memOp combinationally.
- memReady with memOp=0: ignored.

Test Plan:
- Load-use: exMemRead=1, exRt=5, idRs=5 -> one cycle with pcWrite=0, ifIdWrite=0, idExBubble=1; stallCount=1. Repeat with exRt=0 -> no stall.
- Branch plus load-use in the same cycle: branchTaken=1, loadUse=1 -> ifIdFlush=1, idExBubble=1, pcWrite=1; stallCount unchanged.
- Memory wait:
  - memStageRead=1 with memReady low for 3 cycles, then high.
  - Required: 3 cycles with exMemWrite=0, memWbBubble=1; 4th cycle all enables 1; state RUN afterwards; stallCount=3.
- Timeout: TIMEOUT_CYCLES=4, memReady held low.
  - Required: memTimeout rises after the 5th stall cycle; all enables 0 and memReq=0 thereafter.
  - Asserting memReady afterwards has no effect.
- Reset mid-wait: resetN pulled low asynchronously (off-edge) during MEM_WAIT -> memTimeout=0, stallCount=0, state RUN without a clock edge; resumes on release.
- Saturation: CNT_W=4, 20 consecutive memStall cycles with TIMEOUT_CYCLES=255 -> stallCount holds at 15.
